// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states and the
// default datapath sizes that must agree with the 16x16 register bank.
package exec_pkg;

  localparam int unsigned EXEC_WIDTH  = 16;
  localparam int unsigned EXEC_ADDR_W = 4;
  localparam int unsigned OP_W        = 4;
  localparam int unsigned SHAMT_W     = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL = 4'd8;
  localparam logic [OP_W-1:0] OP_SLT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    WB   = 2'd3
  } state_e;

  // Opcodes above SLT are reserved and raise err instead of writing back.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, WIDTH steps,
// keeping only the low WIDTH bits of the product.
module mul_iter
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = EXEC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_product_c,
  output logic             o_done_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_partial;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_partial = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt = r_acc + w_partial;

  // The product includes the current step, so it is complete on the final step edge.
  assign o_product_c = w_acc_nxt;
  assign o_done_c    = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage between the register bank read and write ports: single-cycle
// ALU ops, a 16-step multiply, and a registered writeback triple.
module exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH  = EXEC_WIDTH,
  parameter int unsigned ADDR_W = EXEC_ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] dst,
  input  logic [WIDTH-1:0]  opA,
  input  logic [WIDTH-1:0]  opB,
  output logic              busy,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic              err
);

  state_e            r_state;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_dst;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_busy;
  logic              r_wb_en;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [WIDTH-1:0]  r_wb_data;
  logic              r_flag_z;
  logic              r_flag_c;
  logic              r_err;

  state_e            w_state_nxt;
  logic              w_accept;
  logic              w_busy_nxt;
  logic              w_wb_en_nxt;
  logic [ADDR_W-1:0] w_wb_addr_nxt;
  logic [WIDTH-1:0]  w_wb_data_nxt;
  logic              w_flag_z_nxt;
  logic              w_flag_c_nxt;
  logic              w_err_nxt;
  logic              w_mul_load;
  logic              w_mul_step;
  logic [WIDTH-1:0]  w_product;
  logic              w_mul_done;

  logic [WIDTH:0]    w_sum;
  logic              w_slt;
  logic [WIDTH-1:0]  w_alu_res;
  logic              w_alu_c;

  assign busy    = r_busy;
  assign wb_en   = r_wb_en;
  assign wb_addr = r_wb_addr;
  assign wb_data = r_wb_data;
  assign flag_z  = r_flag_z;
  assign flag_c  = r_flag_c;
  assign err     = r_err;

  mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk        (clock),
    .rst_n      (resetn),
    .i_load     (w_mul_load),
    .i_step     (w_mul_step),
    .i_a        (opA),
    .i_b        (opB),
    .o_product_c(w_product),
    .o_done_c   (w_mul_done)
  );

  // Single-cycle ALU on the captured operands.
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign w_slt = ($signed(r_a) < $signed(r_b));

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_res = r_a - r_b;
        w_alu_c   = (r_a < r_b);
      end
      OP_AND:  w_alu_res = r_a & r_b;
      OP_OR:   w_alu_res = r_a | r_b;
      OP_XOR:  w_alu_res = r_a ^ r_b;
      OP_NOT:  w_alu_res = ~r_a;
      OP_SHL:  w_alu_res = r_a << r_b[SHAMT_W-1:0];
      OP_SHR:  w_alu_res = r_a >> r_b[SHAMT_W-1:0];
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_alu_res = '0;
    endcase
  end

  // Next-state and next-output logic; results and flags hold unless a result lands.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_wb_en_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    w_wb_addr_nxt = r_wb_addr;
    w_wb_data_nxt = r_wb_data;
    w_flag_z_nxt  = r_flag_z;
    w_flag_c_nxt  = r_flag_c;
    w_mul_load    = 1'b0;
    w_mul_step    = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (op == OP_MUL) begin
            w_mul_load  = 1'b1;
            w_state_nxt = MUL;
          end else begin
            w_state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        if (op_is_legal(r_op)) begin
          w_wb_data_nxt = w_alu_res;
          w_wb_addr_nxt = r_dst;
          w_flag_z_nxt  = (w_alu_res == '0);
          w_flag_c_nxt  = w_alu_c;
          w_wb_en_nxt   = 1'b1;
          w_state_nxt   = WB;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      MUL: begin
        w_mul_step = 1'b1;
        if (w_mul_done) begin
          w_wb_data_nxt = w_product;
          w_wb_addr_nxt = r_dst;
          w_flag_z_nxt  = (w_product == '0);
          w_flag_c_nxt  = 1'b0;
          w_wb_en_nxt   = 1'b1;
          w_state_nxt   = WB;
        end
      end
      WB: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_dst     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_busy    <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_flag_z  <= 1'b0;
      r_flag_c  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= w_busy_nxt;
      r_wb_en   <= w_wb_en_nxt;
      r_wb_addr <= w_wb_addr_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_flag_z  <= w_flag_z_nxt;
      r_flag_c  <= w_flag_c_nxt;
      r_err     <= w_err_nxt;
      if (w_accept) begin
        r_op  <= op;
        r_dst <= dst;
        r_a   <= opA;
        r_b   <= opB;
      end
    end
  end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage directly downstream of the 16x16 register bank.
- Consumes the two read operands and produces the writeback triple (data, destination address, write enable) that feeds the bank's write port.
- Single-cycle ALU operations plus an iterative 16-cycle shift-add multiply.
- start/busy handshake toward the decode/control FSM.

Parameters:
- WIDTH, 16, operand/result width; must match register bank data width.
- ADDR_W, 4, register address width (16 registers).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only in IDLE.
- op  input  4  operation code, captured on accept.
- dst  input  ADDR_W  destination register, captured on accept.
- opA  input  WIDTH  operand 1 (bank readData1), captured on accept.
- opB  input  WIDTH  operand 2 (bank readData2), captured on accept.
- busy  output  1  high in any state other than IDLE.
- wb_en  output  1  write enable to bank (in_write).
- wb_addr  output  ADDR_W  write address to bank (ender).
- wb_data  output  WIDTH  write data to bank (data).
- flag_z  output  1  result == 0; updated only with a writeback.
- flag_c  output  1  ADD carry-out / SUB borrow; 0 for all other ops.
- err  output  1  one-cycle pulse on illegal opcode.

Behaviour:
- Reset (async, resetn=0): state IDLE; busy, wb_en, err, flag_z, flag_c = 0; wb_addr = 0; wb_data = 0; multiplier counter = 0.
- Reset asserted mid-operation (including mid-MUL) aborts the operation; no writeback ever issues for the aborted op.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SHL A by B[3:0], 7 SHR (logical) A by B[3:0].
  - 8 MUL: low WIDTH bits of A*B.
  - 9 SLT: signed A<B gives result 1, else 0.
  - 10-15 illegal.
- States: IDLE, EXEC, MUL, WB.
- IDLE: on start=1 at edge N, capture op/dst/opA/opB and go to MUL if op=8, else EXEC. Operands must be stable at edge N; the bank's negedge read guarantees this.
- EXEC, edge N+1: compute the result into wb_data and the flags; go to WB.
- Illegal op in EXEC, edge N+1: err=1 for one cycle, no writeback, go to IDLE.
- MUL:
  - Counter 0..WIDTH-1, one shift-add iteration per edge (edges N+1..N+16).
  - On the edge where counter = WIDTH-1: load the product into wb_data, set flag_z, flag_c=0, go to WB.
  - Overflow beyond WIDTH bits is discarded.
- WB: wb_en=1 for exactly one cycle, then go to IDLE.
  - Single-cycle ops: wb_en high in the cycle after edge N+1.
  - MUL: wb_en high in the cycle after edge N+16.
- wb_data and wb_addr are held stable while wb_en=1 and retained afterwards until the next result.
- start while busy is ignored, not queued.
- start in the same cycle wb_en=1 is ignored; the earliest next accept is the edge after WB.
- Minimum initiation interval: 3 cycles for single-cycle ops, 18 for MUL.
- Arithmetic: all unsigned modulo 2^WIDTH except SLT.
  - ADD carry = bit WIDTH of the WIDTH+1-bit sum.
  - SUB borrow = 1 iff A<B unsigned.
  - Shift amounts 0..15; shift by 0 passes A unchanged.
- dst=0 is treated like any other register; no hardwired zero.

Decomposition:
- Package exec_pkg holds:
  - opcode constants OP_ADD..OP_SLT;
  - state encoding IDLE/EXEC/MUL/WB;
  - default WIDTH/ADDR_W shared with the register bank.
- Sub-module mul_iter: shift-add multiplier.
  - Interface: load, step, operands in, product out, done at count WIDTH-1.
  - Instantiated by exec_stage; all other ops stay in the top-level combinational ALU.

Test Plan:
1. Reset, then ADD opA=0xFFFF opB=0x0001 dst=3 accepted at edge N -> wb_en=1 in the cycle after N+1, wb_addr=3, wb_data=0x0000, flag_z=1, flag_c=1.
2. SUB opA=0x0005 opB=0x0007 -> wb_data=0xFFFE, flag_c=1, flag_z=0. SLT with the same operands -> wb_data=0x0001.
3. MUL opA=0x0123 opB=0x0010 dst=7 at edge N -> busy high for 17 cycles, wb_en=1 in the cycle after N+16, wb_data=0x1230. MUL 0xFFFF*0xFFFF -> 0x0001.
4. SHL opA=0x8001 opB=0x0011 -> wb_data=0x0002. SHR opA=0x8001 opB=0x000F -> 0x0001.
5. op=0xF -> err pulses one cycle after N+1, wb_en never asserts, flags unchanged. start held high during a MUL -> only one writeback occurs.
6. Deassert resetn during MUL iteration 8 -> outputs 0 asynchronously, no wb_en. A new ADD after release completes normally with 2-cycle latency.
